// File: rtl/bram_acc_pkg.sv
// Shared definitions for the BRAM lane accumulator engine:
// FSM state encoding, lane slicing helper and read-latency legality check.
package bram_acc_pkg;

  // FSM state encoding values
  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_READ  = 2'd1;
  localparam logic [1:0] STATE_DRAIN = 2'd2;
  localparam logic [1:0] STATE_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_READ  = STATE_READ,
    ST_DRAIN = STATE_DRAIN,
    ST_DONE  = STATE_DONE
  } state_e;

  // Supported source BRAM read latencies
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

  // LSB position of lane 'lane' in a packed vector of 'width'-bit words
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/bram_acc_lane.sv
// One lane accumulator: synchronous clear, valid-gated add of a
// zero-extended input word. With BRAM_ACC_SAT_EN defined the sum clamps
// at all-ones and sat_o flags the saturating add; otherwise it wraps.
module bram_acc_lane
  import bram_acc_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [IN_W-1:0]  din_i,
  output logic [ACC_W-1:0] acc_o
`ifdef BRAM_ACC_SAT_EN
  ,
  output logic             sat_o
`endif
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

`ifdef BRAM_ACC_SAT_EN
  logic [ACC_W:0] sum_wide;

  // Next sum with one extra carry bit; a carry means the lane clamps
  always_comb begin
    sum_wide = {1'b0, acc_q} + (ACC_W+1)'(din_i);
    acc_d    = acc_q;
    sat_o    = 1'b0;
    if (clr_i) begin
      acc_d = '0;
    end else if (vld_i) begin
      if (sum_wide[ACC_W]) begin
        acc_d = '1;
        sat_o = 1'b1;
      end else begin
        acc_d = sum_wide[ACC_W-1:0];
      end
    end
  end
`else
  // Next sum, wrapping modulo 2^ACC_W
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (vld_i) begin
      acc_d = acc_q + ACC_W'(din_i);
    end
  end
`endif

  // Accumulator register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/bram_acc_engine.sv
// Lane-parallel accumulator streaming rows from source BRAM0 and writing
// lane sums to destination BRAM1, either every row (mode 0) or once at the
// end to address 0 (mode 1). Optional macro BRAM_ACC_SAT_EN enables
// per-lane saturation and the sticky ovf_o flag.
module bram_acc_engine
  import bram_acc_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int IN_W   = 8,
  parameter int ACC_W  = 16,
  parameter int AWIDTH = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = AWIDTH + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic [CNT_W-1:0]       run_count_i,
  input  logic                   mode_i,
  input  logic [LANES*IN_W-1:0]  q_b0_i,
  output logic [AWIDTH-1:0]      addr_b0_o,
  output logic                   ce_b0_o,
  output logic                   we_b0_o,
  output logic [AWIDTH-1:0]      addr_b1_o,
  output logic                   ce_b1_o,
  output logic                   we_b1_o,
  output logic [LANES*ACC_W-1:0] d_b1_o,
  output logic                   idle_o,
  output logic                   read_o,
  output logic                   drain_o,
  output logic                   done_o,
  output logic                   ovf_o
);

  // Largest row count one run can address without wrapping
  localparam logic [CNT_W-1:0] MAX_ROWS = CNT_W'(2 ** AWIDTH);

  generate
    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
      $error("bram_acc_engine: RD_LAT must be in 1..3");
    end
  endgenerate

  state_e             state_q, state_d;
  logic               ce_b0_q, ce_b0_d;
  logic [AWIDTH-1:0]  addr_b0_q, addr_b0_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               mode_q, mode_d;
  logic [RD_LAT-1:0]  vld_pipe_q, vld_pipe_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic               ce_b1_q, ce_b1_d;
  logic [AWIDTH-1:0]  addr_b1_q, addr_b1_d;
  logic               last_wr_q, last_wr_d;
  logic               idle_q, idle_d;
  logic               read_q, read_d;
  logic               drain_q, drain_d;
  logic               done_q, done_d;

  logic               start_ok;
  logic               row_vld;
  logic               row_last;

  // Read data for the row strobed RD_LAT cycles ago is on q_b0_i now
  assign row_vld  = vld_pipe_q[RD_LAT-1];
  assign row_last = (wr_cnt_q == (count_q - CNT_W'(1)));

  // Next-state logic for the FSM, both BRAM ports and the status flags
  always_comb begin
    state_d    = state_q;
    ce_b0_d    = 1'b0;
    addr_b0_d  = addr_b0_q;
    rd_cnt_d   = rd_cnt_q;
    count_d    = count_q;
    mode_d     = mode_q;
    wr_cnt_d   = wr_cnt_q;
    ce_b1_d    = 1'b0;
    addr_b1_d  = addr_b1_q;
    last_wr_d  = 1'b0;
    start_ok   = 1'b0;
    vld_pipe_d = RD_LAT'({vld_pipe_q, ce_b0_q});

    // Each consumed row updates the sums; the write strobe follows one
    // cycle later so d_b1_o already carries the updated registers.
    if (row_vld) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
      if (!mode_q || row_last) begin
        ce_b1_d   = 1'b1;
        addr_b1_d = mode_q ? '0 : wr_cnt_q[AWIDTH-1:0];
        last_wr_d = row_last;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          start_ok = 1'b1;
          count_d  = (run_count_i > MAX_ROWS) ? MAX_ROWS : run_count_i;
          mode_d   = mode_i;
          wr_cnt_d = '0;
          if (run_count_i == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_READ;
            ce_b0_d   = 1'b1;
            addr_b0_d = '0;
            rd_cnt_d  = CNT_W'(1);
          end
        end
      end
      ST_READ: begin
        if (rd_cnt_q == count_q) begin
          state_d = ST_DRAIN;
        end else begin
          ce_b0_d   = 1'b1;
          addr_b0_d = rd_cnt_q[AWIDTH-1:0];
          rd_cnt_d  = rd_cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (ce_b1_q && last_wr_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    idle_d  = (state_d == ST_IDLE);
    read_d  = (state_d == ST_READ);
    drain_d = (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
  end

  // FSM, counters and registered control outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ce_b0_q    <= 1'b0;
      addr_b0_q  <= '0;
      rd_cnt_q   <= '0;
      count_q    <= '0;
      mode_q     <= 1'b0;
      vld_pipe_q <= '0;
      wr_cnt_q   <= '0;
      ce_b1_q    <= 1'b0;
      addr_b1_q  <= '0;
      last_wr_q  <= 1'b0;
      idle_q     <= 1'b1;
      read_q     <= 1'b0;
      drain_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ce_b0_q    <= ce_b0_d;
      addr_b0_q  <= addr_b0_d;
      rd_cnt_q   <= rd_cnt_d;
      count_q    <= count_d;
      mode_q     <= mode_d;
      vld_pipe_q <= vld_pipe_d;
      wr_cnt_q   <= wr_cnt_d;
      ce_b1_q    <= ce_b1_d;
      addr_b1_q  <= addr_b1_d;
      last_wr_q  <= last_wr_d;
      idle_q     <= idle_d;
      read_q     <= read_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
    end
  end

`ifdef BRAM_ACC_SAT_EN
  logic [LANES-1:0] lane_sat;
`endif

  // One accumulator per packed input word
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      bram_acc_lane #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (start_ok),
        .vld_i   (row_vld),
        .din_i   (q_b0_i[lane_lsb(gi, IN_W) +: IN_W]),
        .acc_o   (d_b1_o[lane_lsb(gi, ACC_W) +: ACC_W])
`ifdef BRAM_ACC_SAT_EN
        ,
        .sat_o   (lane_sat[gi])
`endif
      );
    end
  endgenerate

`ifdef BRAM_ACC_SAT_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: set by any saturating lane, cleared by an accepted start
  always_comb begin
    ovf_d = ovf_q | (|lane_sat);
    if (start_ok) begin
      ovf_d = 1'b0;
    end
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign addr_b0_o = addr_b0_q;
  assign ce_b0_o   = ce_b0_q;
  assign we_b0_o   = 1'b0;
  assign addr_b1_o = addr_b1_q;
  assign ce_b1_o   = ce_b1_q;
  assign we_b1_o   = ce_b1_q;
  assign idle_o    = idle_q;
  assign read_o    = read_q;
  assign drain_o   = drain_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_bram_acc_engine.sv
// Directed bench for bram_acc_engine. Three instances share one source
// memory image: default parameters, RD_LAT=3 and ACC_W=15. Expectations
// for the ACC_W=15 run follow BRAM_ACC_SAT_EN.
module tb_bram_acc_engine;

  localparam int CW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic [2:0]    start = '0;
  logic [CW-1:0] run_count = '0;
  logic          mode = 1'b0;
  logic [31:0]   src_mem [0:255];
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // dut0: defaults
  logic [7:0]  addr0_b0, addr0_b1;
  logic        ce0_b0, we0_b0, ce0_b1, we0_b1, idle0, read0, drain0, done0, ovf0;
  logic [63:0] d0;
  logic [31:0] q0 = '0;
  // dut1: RD_LAT = 3
  logic [7:0]  addr1_b0, addr1_b1;
  logic        ce1_b0, we1_b0, ce1_b1, we1_b1, idle1, read1, drain1, done1, ovf1;
  logic [63:0] d1;
  logic [31:0] p1a = '0, p1b = '0, q1 = '0;
  // dut2: ACC_W = 15
  logic [7:0]  addr2_b0, addr2_b1;
  logic        ce2_b0, we2_b0, ce2_b1, we2_b1, idle2, read2, drain2, done2, ovf2;
  logic [59:0] d2;
  logic [31:0] q2 = '0;

  bram_acc_engine u_dut0 (
    .clk(clk), .reset_n(reset_n), .start_i(start[0]), .run_count_i(run_count),
    .mode_i(mode), .q_b0_i(q0), .addr_b0_o(addr0_b0), .ce_b0_o(ce0_b0),
    .we_b0_o(we0_b0), .addr_b1_o(addr0_b1), .ce_b1_o(ce0_b1), .we_b1_o(we0_b1),
    .d_b1_o(d0), .idle_o(idle0), .read_o(read0), .drain_o(drain0),
    .done_o(done0), .ovf_o(ovf0)
  );

  bram_acc_engine #(.RD_LAT(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start_i(start[1]), .run_count_i(run_count),
    .mode_i(mode), .q_b0_i(q1), .addr_b0_o(addr1_b0), .ce_b0_o(ce1_b0),
    .we_b0_o(we1_b0), .addr_b1_o(addr1_b1), .ce_b1_o(ce1_b1), .we_b1_o(we1_b1),
    .d_b1_o(d1), .idle_o(idle1), .read_o(read1), .drain_o(drain1),
    .done_o(done1), .ovf_o(ovf1)
  );

  bram_acc_engine #(.ACC_W(15)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start_i(start[2]), .run_count_i(run_count),
    .mode_i(mode), .q_b0_i(q2), .addr_b0_o(addr2_b0), .ce_b0_o(ce2_b0),
    .we_b0_o(we2_b0), .addr_b1_o(addr2_b1), .ce_b1_o(ce2_b1), .we_b1_o(we2_b1),
    .d_b1_o(d2), .idle_o(idle2), .read_o(read2), .drain_o(drain2),
    .done_o(done2), .ovf_o(ovf2)
  );

  // Source BRAM models; reads without a strobe return garbage
  always @(posedge clk) q0 <= ce0_b0 ? src_mem[addr0_b0] : 32'hDEADBEEF;
  always @(posedge clk) begin
    p1a <= ce1_b0 ? src_mem[addr1_b0] : 32'hDEADBEEF;
    p1b <= p1a;
    q1  <= p1b;
  end
  always @(posedge clk) q2 <= ce2_b0 ? src_mem[addr2_b0] : 32'hDEADBEEF;

  logic [2:0] done_v, idle_v;
  assign done_v = {done2, done1, done0};
  assign idle_v = {idle2, idle1, idle0};

  // Per-instance bus monitor state
  int          nwr[3], ce0_cnt[3], done_cnt[3], seq_err[3], we_err[3], oh_err[3];
  int          ce0_rise[3], ce1_rise[3];
  logic [7:0]  first_addr[3], last_addr[3];
  logic [63:0] first_data[3], last_data[3];
  logic        prev_ce0[3], prev_ce1[3];

  task automatic mon_step(input int d, input logic c0, input logic w0, input logic c1,
                          input logic w1, input logic [7:0] a1, input logic [63:0] dat,
                          input logic [3:0] flags);
    if (c0) ce0_cnt[d]++;
    if (c0 && !prev_ce0[d]) ce0_rise[d] = cyc;
    if (w0 || (w1 != c1)) we_err[d]++;
    if ($countones(flags) != 1) oh_err[d]++;
    if (c1) begin
      if (!prev_ce1[d]) begin
        ce1_rise[d]   = cyc;
        first_addr[d] = a1;
        first_data[d] = dat;
      end else if (a1 != last_addr[d] + 8'd1) begin
        seq_err[d]++;
      end
      nwr[d]++;
      last_addr[d] = a1;
      last_data[d] = dat;
    end
    if (flags[3]) done_cnt[d]++;
    prev_ce0[d] = c0;
    prev_ce1[d] = c1;
  endtask

  always @(negedge clk) begin
    mon_step(0, ce0_b0, we0_b0, ce0_b1, we0_b1, addr0_b1, d0, {done0, drain0, read0, idle0});
    mon_step(1, ce1_b0, we1_b0, ce1_b1, we1_b1, addr1_b1, d1, {done1, drain1, read1, idle1});
    mon_step(2, ce2_b0, we2_b0, ce2_b1, we2_b1, addr2_b1, {4'h0, d2}, {done2, drain2, read2, idle2});
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Test-side activity happens just after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int   s_nwr, s_ce0, s_done, s_seq, run_lat;
  logic post_idle, post_done;

  task automatic start_run(input int d, input int cnt, input bit m);
    s_nwr  = nwr[d];
    s_ce0  = ce0_cnt[d];
    s_done = done_cnt[d];
    s_seq  = seq_err[d];
    run_count = CW'(cnt);
    mode      = m;
    start[d]  = 1'b1;
    tick();
    start[d]  = 1'b0;
  endtask

  task automatic finish_run(input int d);
    int n = 0;
    while (!done_v[d] && n < 2000) begin
      tick();
      n++;
    end
    run_lat = n;
    check_eq("done_seen", 64'(done_v[d]), 64'd1);
    tick();
    post_idle = idle_v[d];
    post_done = done_v[d];
    $display("run dut%0d: writes=%0d reads=%0d last_addr=%0d last_data=%h",
             d, nwr[d] - s_nwr, ce0_cnt[d] - s_ce0, last_addr[d], last_data[d]);
  endtask

  localparam logic [63:0] SUM4   = 64'h0010_000C_0008_0004;
  localparam logic [63:0] ROW1   = 64'h0004_0003_0002_0001;
  localparam logic [63:0] SUM_FF = 64'hFF00_FF00_FF00_FF00;
`ifdef BRAM_ACC_SAT_EN
  localparam logic [63:0] EXP_W15   = {4'h0, {4{15'h7FFF}}};
  localparam logic [63:0] EXP_OVF15 = 64'd1;
`else
  localparam logic [63:0] EXP_W15   = {4'h0, {4{15'h7F00}}};
  localparam logic [63:0] EXP_OVF15 = 64'd0;
`endif

  initial begin
    for (int i = 0; i < 256; i++) src_mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) src_mem[i] = 32'h04030201;

    // Reset state
    repeat (3) tick();
    check_eq("rst_idle", 64'(idle0), 64'd1);
    check_eq("rst_flags", 64'({read0, drain0, done0}), 64'd0);
    check_eq("rst_strobes", 64'({ce0_b0, we0_b0, ce0_b1, we0_b1}), 64'd0);
    check_eq("rst_addr", 64'({addr0_b0, addr0_b1}), 64'd0);
    check_eq("rst_data", d0, 64'd0);
    check_eq("rst_ovf", 64'(ovf0), 64'd0);
    reset_n = 1'b1;
    tick();

    // Mode 0, four rows
    start_run(0, 4, 1'b0);
    finish_run(0);
    check_eq("m0_nwr", 64'(nwr[0] - s_nwr), 64'd4);
    check_eq("m0_first_addr", 64'(first_addr[0]), 64'd0);
    check_eq("m0_first_data", first_data[0], ROW1);
    check_eq("m0_last_addr", 64'(last_addr[0]), 64'd3);
    check_eq("m0_last_data", last_data[0], SUM4);
    check_eq("m0_seq", 64'(seq_err[0] - s_seq), 64'd0);
    check_eq("m0_reads", 64'(ce0_cnt[0] - s_ce0), 64'd4);
    check_eq("m0_wr_latency", 64'(ce1_rise[0] - ce0_rise[0]), 64'd2);
    check_eq("m0_done_once", 64'(done_cnt[0] - s_done), 64'd1);
    check_eq("m0_idle_after", 64'({post_idle, post_done}), 64'b10);

    // Mode 1, same data
    start_run(0, 4, 1'b1);
    finish_run(0);
    check_eq("m1_nwr", 64'(nwr[0] - s_nwr), 64'd1);
    check_eq("m1_addr", 64'(last_addr[0]), 64'd0);
    check_eq("m1_data", last_data[0], SUM4);

    // Zero-length run
    start_run(0, 0, 1'b0);
    finish_run(0);
    check_eq("n0_latency", 64'(run_lat), 64'd0);
    check_eq("n0_reads", 64'(ce0_cnt[0] - s_ce0), 64'd0);
    check_eq("n0_writes", 64'(nwr[0] - s_nwr), 64'd0);

    // Full address range of all-ones rows
    for (int i = 0; i < 256; i++) src_mem[i] = 32'hFFFFFFFF;
    start_run(0, 256, 1'b0);
    finish_run(0);
    check_eq("ff_nwr", 64'(nwr[0] - s_nwr), 64'd256);
    check_eq("ff_last_addr", 64'(last_addr[0]), 64'd255);
    check_eq("ff_last_data", last_data[0], SUM_FF);
    check_eq("ff_seq", 64'(seq_err[0] - s_seq), 64'd0);
    check_eq("ff_ovf", 64'(ovf0), 64'd0);

    // Oversized count clamps to the address range
    start_run(0, 511, 1'b1);
    finish_run(0);
    check_eq("clamp_reads", 64'(ce0_cnt[0] - s_ce0), 64'd256);
    check_eq("clamp_data", last_data[0], SUM_FF);

    // Narrow accumulators: wrap or saturate
    start_run(2, 256, 1'b1);
    finish_run(2);
    check_eq("w15_nwr", 64'(nwr[2] - s_nwr), 64'd1);
    check_eq("w15_data", last_data[2], EXP_W15);
    check_eq("w15_ovf", 64'(ovf2), EXP_OVF15);

    // Three-cycle read latency
    src_mem[0] = 32'h01020304;
    src_mem[1] = 32'h10203040;
    src_mem[2] = 32'h0A0B0C0D;
    src_mem[3] = 32'hFFFFFFFF;
    src_mem[4] = 32'h00000001;
    start_run(1, 5, 1'b0);
    finish_run(1);
    check_eq("lat3_wr_latency", 64'(ce1_rise[1] - ce0_rise[1]), 64'd4);
    check_eq("lat3_nwr", 64'(nwr[1] - s_nwr), 64'd5);
    check_eq("lat3_first_data", first_data[1], 64'h0001_0002_0003_0004);
    check_eq("lat3_last_addr", 64'(last_addr[1]), 64'd4);
    check_eq("lat3_last_data", last_data[1], 64'h011A_012C_013E_0151);
    check_eq("lat3_ovf", 64'(ovf1), 64'd0);

    // Second start and input changes during READ are ignored
    for (int i = 0; i < 4; i++) src_mem[i] = 32'h04030201;
    start_run(0, 4, 1'b0);
    tick();
    start[0]  = 1'b1;
    run_count = CW'(2);
    mode      = 1'b1;
    tick();
    start[0]  = 1'b0;
    finish_run(0);
    check_eq("restart_nwr", 64'(nwr[0] - s_nwr), 64'd4);
    check_eq("restart_reads", 64'(ce0_cnt[0] - s_ce0), 64'd4);
    check_eq("restart_data", last_data[0], SUM4);

    // Reset in the middle of READ
    start_run(0, 8, 1'b0);
    tick();
    reset_n = 1'b0;
    tick();
    check_eq("abort_strobes", 64'({ce0_b0, ce0_b1}), 64'd0);
    check_eq("abort_flags", 64'({idle0, read0, drain0, done0}), 64'b1000);
    s_ce0 = ce0_cnt[0];
    s_nwr = nwr[0];
    repeat (3) tick();
    check_eq("abort_quiet", 64'((ce0_cnt[0] - s_ce0) + (nwr[0] - s_nwr)), 64'd0);
    reset_n = 1'b1;
    tick();
    start_run(0, 4, 1'b0);
    finish_run(0);
    check_eq("fresh_nwr", 64'(nwr[0] - s_nwr), 64'd4);
    check_eq("fresh_data", last_data[0], SUM4);

    // Whole-run protocol invariants
    check_eq("we_rules", 64'(we_err[0] + we_err[1] + we_err[2]), 64'd0);
    check_eq("onehot_flags", 64'(oh_err[0] + oh_err[1] + oh_err[2]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
